// File: rtl/replica_sequencer.sv
// Run controller for the replica chain: loads the distance RAM, shifts replicas in/out
// and loops the DIST/SWAP phases with alternating exchange parity.
package replica_sequencer_pkg;
  localparam int unsigned DIST_W = 16;

  typedef logic [DIST_W-1:0] distance_data_t;

  typedef enum logic [1:0] {NOP = 2'd0, PREV = 2'd1, FOLW = 2'd2} exchange_command_t;
  typedef enum logic [2:0] {KN, KM, KP, LN, LP, LM} dist_sel_t;
  typedef enum logic [1:0] {DNOP, ZERO, MNS, PLS} dist_op_t;

  typedef struct packed {
    dist_sel_t sel;
    dist_op_t  op;
  } distance_command_t;

  typedef enum logic [1:0] {OR0, OR1, TWO, THR} opt_command_t;
endpackage

module replica_sequencer
  import replica_sequencer_pkg::*;
#(
  parameter int unsigned REPLICA_NUM = 4,
  parameter int unsigned CITY_NUM    = 32,
  parameter int unsigned CITY_DIV    = 4,
  parameter int unsigned DIST_CYC    = 20,
  parameter int unsigned SWAP_CYC    = 10,
  parameter int unsigned ITER_W      = 16,
  localparam int unsigned CITY_NUM_LOG = $clog2(CITY_NUM),
  localparam int unsigned ADDR_W       = 2 * CITY_NUM_LOG
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [1:0]              mode,
  input  logic [ITER_W-1:0]       iter_num,
  input  logic                    dist_in_valid,
  output logic                    dist_in_ready,
  input  distance_data_t          dist_in_data,
  output logic                    dist_we,
  output logic [ADDR_W-1:0]       dist_waddr,
  output distance_data_t          dist_wdata,
  input  logic                    sft_in_valid,
  output logic                    sft_in_ready,
  output logic                    shift_valid,
  output logic                    shift_out,
  output exchange_command_t [1:0] c_exchange,
  output distance_command_t       c_distance,
  output opt_command_t            opt_cmd,
  output logic                    rbank,
  output logic                    busy,
  output logic                    done,
  output logic [ITER_W-1:0]       iter_cnt
);

  localparam int unsigned DIST_DEPTH = CITY_NUM * (CITY_NUM + 1) / 2;
  localparam int unsigned BEATS      = REPLICA_NUM * CITY_DIV;
  localparam int unsigned BEAT_W     = $clog2(BEATS);
  localparam int unsigned STEP_MAX   = (DIST_CYC > SWAP_CYC) ? DIST_CYC : SWAP_CYC;
  localparam int unsigned STEP_W     = $clog2(STEP_MAX);

  localparam distance_command_t       DIST_IDLE = '{sel: KN, op: DNOP};
  localparam exchange_command_t [1:0] EX_NONE   = '{NOP, NOP};
  localparam exchange_command_t [1:0] EX_SHIFT  = '{PREV, PREV};

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SFTI, S_DIST, S_SWAP, S_SFTO, S_DONE} state_t;

  state_t                  state, state_d;
  opt_command_t            mode_q, mode_d;
  logic [ITER_W-1:0]       iter_num_q, iter_num_d, iter_cnt_d, iter_inc;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [BEAT_W-1:0]       beat_q, beat_d;
  logic [STEP_W-1:0]       step_q, step_d;
  logic                    beat_head;

  logic                    dist_we_d;
  logic [ADDR_W-1:0]       dist_waddr_d;
  distance_data_t          dist_wdata_d;
  logic                    shift_valid_d, shift_out_d, rbank_d, busy_d, done_d;
  exchange_command_t [1:0] c_exchange_d;
  distance_command_t       c_distance_d;
  opt_command_t            opt_cmd_d;

  // Per-step distance command table; steps past the programmed sequence idle.
  function automatic distance_command_t dist_cmd(input logic two, input int unsigned s);
    distance_command_t c;
    c = DIST_IDLE;
    if (two) begin
      case (s)
        32'd0:   c = '{KN, ZERO};
        32'd1:   c = '{KM, MNS};
        32'd2:   c = '{LM, PLS};
        32'd3:   c = '{LN, MNS};
        32'd4:   c = '{KN, PLS};
        default: c = DIST_IDLE;
      endcase
    end else begin
      case (s)
        32'd0:   c = '{KN, ZERO};
        32'd1:   c = '{KM, MNS};
        32'd2:   c = '{KP, PLS};
        32'd3:   c = '{KN, MNS};
        32'd4:   c = '{LN, PLS};
        32'd5:   c = '{LP, MNS};
        32'd6:   c = '{KN, PLS};
        default: c = DIST_IDLE;
      endcase
    end
    return c;
  endfunction

  assign dist_in_ready = (state == S_LOAD);
  assign sft_in_ready  = (state == S_SFTI);
  assign beat_head     = ((beat_q % BEAT_W'(CITY_DIV)) == '0);
  assign iter_inc      = iter_cnt + ITER_W'(1);

  // Next state, counters and next registered outputs.
  always_comb begin
    state_d       = state;
    mode_d        = mode_q;
    iter_num_d    = iter_num_q;
    iter_cnt_d    = iter_cnt;
    addr_d        = addr_q;
    beat_d        = beat_q;
    step_d        = step_q;
    dist_we_d     = 1'b0;
    dist_waddr_d  = dist_waddr;
    dist_wdata_d  = dist_wdata;
    shift_valid_d = 1'b0;
    shift_out_d   = 1'b0;
    c_exchange_d  = EX_NONE;
    c_distance_d  = DIST_IDLE;
    opt_cmd_d     = THR;
    done_d        = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          mode_d     = (mode == 2'd3) ? TWO : opt_command_t'(mode);
          iter_num_d = iter_num;
          iter_cnt_d = '0;
          addr_d     = '0;
          beat_d     = '0;
          step_d     = '0;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        if (dist_in_valid) begin
          dist_we_d    = 1'b1;
          dist_waddr_d = addr_q;
          dist_wdata_d = dist_in_data;
          if (addr_q == ADDR_W'(DIST_DEPTH - 1)) begin
            addr_d  = '0;
            state_d = S_SFTI;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
      S_SFTI: begin
        if (sft_in_valid) begin
          shift_valid_d = 1'b1;
          if (beat_head) c_exchange_d = EX_SHIFT;
          if (beat_q == BEAT_W'(BEATS - 1)) begin
            beat_d  = '0;
            step_d  = '0;
            state_d = (iter_num_q != '0) ? S_DIST : S_SFTO;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      S_DIST: begin
        opt_cmd_d    = mode_q;
        c_distance_d = dist_cmd(mode_q == TWO, 32'(step_q));
        if (step_q == STEP_W'(DIST_CYC - 1)) begin
          step_d  = '0;
          state_d = S_SWAP;
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end
      S_SWAP: begin
        opt_cmd_d = mode_q;
        // Even iterations pair 0-1,2-3,...; odd iterations pair 1-2,3-4,...
        if (step_q == '0) begin
          c_exchange_d[0] = iter_cnt[0] ? PREV : FOLW;
          c_exchange_d[1] = iter_cnt[0] ? FOLW : PREV;
        end
        if (step_q == STEP_W'(SWAP_CYC - 1)) begin
          step_d = '0;
          beat_d = '0;
          if (iter_cnt != iter_num_q) iter_cnt_d = iter_inc;
          state_d = (iter_inc == iter_num_q) ? S_SFTO : S_DIST;
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end
      S_SFTO: begin
        shift_valid_d = 1'b1;
        shift_out_d   = 1'b1;
        if (beat_head) c_exchange_d = EX_SHIFT;
        if (beat_q == BEAT_W'(BEATS - 1)) begin
          beat_d  = '0;
          state_d = S_DONE;
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d  = (state_d != S_IDLE);
    rbank_d = rbank ^ ((c_exchange_d[0] != NOP) || (c_exchange_d[1] != NOP));
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      mode_q      <= OR0;
      iter_num_q  <= '0;
      iter_cnt    <= '0;
      addr_q      <= '0;
      beat_q      <= '0;
      step_q      <= '0;
      dist_we     <= 1'b0;
      dist_waddr  <= '0;
      dist_wdata  <= '0;
      shift_valid <= 1'b0;
      shift_out   <= 1'b0;
      c_exchange  <= EX_NONE;
      c_distance  <= DIST_IDLE;
      opt_cmd     <= THR;
      rbank       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_d;
      mode_q      <= mode_d;
      iter_num_q  <= iter_num_d;
      iter_cnt    <= iter_cnt_d;
      addr_q      <= addr_d;
      beat_q      <= beat_d;
      step_q      <= step_d;
      dist_we     <= dist_we_d;
      dist_waddr  <= dist_waddr_d;
      dist_wdata  <= dist_wdata_d;
      shift_valid <= shift_valid_d;
      shift_out   <= shift_out_d;
      c_exchange  <= c_exchange_d;
      c_distance  <= c_distance_d;
      opt_cmd     <= opt_cmd_d;
      rbank       <= rbank_d;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

endmodule

// File: tb/tb_replica_sequencer.sv
// Scoreboard bench for replica_sequencer: randomized runs checked against a queue-based
// reference of the expected write, shift, exchange and distance-command streams.
`timescale 1ns/1ps
module tb_replica_sequencer;
  import replica_sequencer_pkg::*;

  localparam int DEPTH      = 528;
  localparam int BEATS      = 16;
  localparam int CDIV       = 4;
  localparam int ITER_CYC   = 30;
  localparam int WAIT_LIMIT = 4000;

  typedef exchange_command_t [1:0] ex_pair_t;
  typedef struct packed { logic [9:0] addr; distance_data_t data; } wr_t;
  typedef struct packed { logic out; ex_pair_t ex; } sh_t;

  localparam ex_pair_t          EX_NONE   = '{NOP, NOP};
  localparam distance_command_t DIST_IDLE = '{sel: KN, op: DNOP};

  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [15:0] iter_num = 16'd0;
  logic dist_in_valid = 1'b0, dist_in_ready, sft_in_valid = 1'b0, sft_in_ready;
  distance_data_t dist_in_data = '0;
  logic dist_we, shift_valid, shift_out, rbank, busy, done;
  logic [9:0] dist_waddr;
  distance_data_t dist_wdata;
  ex_pair_t c_exchange;
  distance_command_t c_distance;
  opt_command_t opt_cmd;
  logic [15:0] iter_cnt;

  replica_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .iter_num(iter_num),
    .dist_in_valid(dist_in_valid), .dist_in_ready(dist_in_ready), .dist_in_data(dist_in_data),
    .dist_we(dist_we), .dist_waddr(dist_waddr), .dist_wdata(dist_wdata),
    .sft_in_valid(sft_in_valid), .sft_in_ready(sft_in_ready),
    .shift_valid(shift_valid), .shift_out(shift_out), .c_exchange(c_exchange),
    .c_distance(c_distance), .opt_cmd(opt_cmd), .rbank(rbank), .busy(busy),
    .done(done), .iter_cnt(iter_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0, bad = 0;
  wr_t wr_q[$];
  sh_t sh_q[$];
  ex_pair_t sw_q[$];
  distance_command_t dc_q[$];
  distance_data_t data[DEPTH];
  distance_command_t seq_or[7];
  distance_command_t seq_two[5];

  opt_command_t exp_opt = THR;
  int exp_iter = 0, exp_len = 0, exp_toggles = 0;
  int start_cyc = 0, tog_base = 0, toggles = 0;
  logic prev_rbank = 1'b0;
  bit done_seen = 1'b0;

  task automatic chk(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic ex_pair_t pair(input exchange_command_t e0, input exchange_command_t e1);
    ex_pair_t p;
    p[0] = e0;
    p[1] = e1;
    return p;
  endfunction

  task automatic check_reset();
    chk("rst_dist_we", dist_we == 1'b0, 64'(dist_we), 64'(0));
    chk("rst_shift_valid", shift_valid == 1'b0, 64'(shift_valid), 64'(0));
    chk("rst_shift_out", shift_out == 1'b0, 64'(shift_out), 64'(0));
    chk("rst_c_exchange", c_exchange == EX_NONE, 64'(c_exchange), 64'(EX_NONE));
    chk("rst_c_distance", c_distance == DIST_IDLE, 64'(c_distance), 64'(DIST_IDLE));
    chk("rst_opt_cmd", opt_cmd == THR, 64'(opt_cmd), 64'(THR));
    chk("rst_rbank", rbank == 1'b0, 64'(rbank), 64'(0));
    chk("rst_busy", busy == 1'b0, 64'(busy), 64'(0));
    chk("rst_done", done == 1'b0, 64'(done), 64'(0));
    chk("rst_iter_cnt", iter_cnt == 16'd0, 64'(iter_cnt), 64'(0));
    chk("rst_dist_in_ready", dist_in_ready == 1'b0, 64'(dist_in_ready), 64'(0));
    chk("rst_sft_in_ready", sft_in_ready == 1'b0, 64'(sft_in_ready), 64'(0));
  endtask

  // Monitor: pops the expected stream matching whatever the DUT presents.
  initial begin : monitor
    wr_t w;
    sh_t s;
    ex_pair_t x;
    distance_command_t d;
    forever begin
      @(posedge clk);
      #1;
      if (!reset && rbank != prev_rbank) toggles++;
      prev_rbank = rbank;
      if (!reset) begin
        if (dist_we) begin
          if (wr_q.size() == 0) chk("write_extra", 1'b0, 64'(dist_waddr), 64'(0));
          else begin
            w = wr_q.pop_front();
            chk("write", {dist_waddr, dist_wdata} == w, 64'({dist_waddr, dist_wdata}), 64'(w));
          end
        end
        if (shift_valid) begin
          if (sh_q.size() == 0) chk("shift_extra", 1'b0, 64'({shift_out, c_exchange}), 64'(0));
          else begin
            s = sh_q.pop_front();
            chk("shift_beat", {shift_out, c_exchange} == s, 64'({shift_out, c_exchange}), 64'(s));
          end
          chk("shift_opt", opt_cmd == THR, 64'(opt_cmd), 64'(THR));
        end else if (c_exchange != EX_NONE) begin
          if (sw_q.size() == 0) chk("swap_extra", 1'b0, 64'(c_exchange), 64'(EX_NONE));
          else begin
            x = sw_q.pop_front();
            chk("swap_exchange", c_exchange == x, 64'(c_exchange), 64'(x));
          end
        end
        if (c_distance != DIST_IDLE) begin
          if (dc_q.size() == 0) chk("distance_extra", 1'b0, 64'(c_distance), 64'(DIST_IDLE));
          else begin
            d = dc_q.pop_front();
            chk("distance_cmd", c_distance == d, 64'(c_distance), 64'(d));
          end
        end
        if (opt_cmd != THR)
          chk("opt_cmd", (exp_iter != 0) && (opt_cmd == exp_opt), 64'(opt_cmd), 64'(exp_opt));
        if (done) begin
          chk("done_iter_cnt", iter_cnt == 16'(exp_iter), 64'(iter_cnt), 64'(exp_iter));
          chk("done_rbank_toggles", (toggles - tog_base) == exp_toggles,
              64'(toggles - tog_base), 64'(exp_toggles));
          if (exp_len != 0)
            chk("run_length", (cyc - start_cyc) == exp_len, 64'(cyc - start_cyc), 64'(exp_len));
          done_seen = 1'b1;
        end
      end
    end
  end

  // One run: build the expected streams, then drive. sfti_pat 0=high, 1=toggle, 2=random.
  task automatic run(input logic [1:0] m, input int it, input bit stall_ld, input int sfti_pat,
                     input bit glitch, input int abort_at);
    int i, n;
    bit acc;
    bit two;
    two = (m >= 2'd2);
    exp_opt = two ? TWO : opt_command_t'(m);
    exp_iter = it;
    exp_toggles = 2 * (BEATS / CDIV) + it;
    exp_len = (!stall_ld && sfti_pat == 0) ? DEPTH + 2 * BEATS + it * ITER_CYC + 1 : 0;
    for (int a = 0; a < DEPTH; a++) begin
      data[a] = distance_data_t'($urandom);
      wr_q.push_back('{addr: 10'(a), data: data[a]});
    end
    for (int b = 0; b < BEATS; b++)
      sh_q.push_back('{out: 1'b0, ex: (b % CDIV == 0) ? pair(PREV, PREV) : EX_NONE});
    for (int k = 0; k < it; k++) begin
      if (two) foreach (seq_two[j]) dc_q.push_back(seq_two[j]);
      else     foreach (seq_or[j])  dc_q.push_back(seq_or[j]);
      sw_q.push_back((k % 2 == 0) ? pair(FOLW, PREV) : pair(PREV, FOLW));
    end
    for (int b = 0; b < BEATS; b++)
      sh_q.push_back('{out: 1'b1, ex: (b % CDIV == 0) ? pair(PREV, PREV) : EX_NONE});

    done_seen = 1'b0;
    mode = m;
    iter_num = 16'(it);
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    start_cyc = cyc;
    tog_base = toggles;
    mode = 2'($urandom);
    iter_num = 16'($urandom);

    i = 0;
    n = 0;
    while (i < DEPTH && n < DEPTH * 8) begin
      dist_in_valid = stall_ld ? 1'($urandom_range(0, 1)) : 1'b1;
      dist_in_data = data[i];
      acc = dist_in_valid && dist_in_ready;
      @(posedge clk);
      #2;
      n++;
      if (acc) i++;
    end
    dist_in_valid = 1'b0;
    chk("load_accepted", i == DEPTH, 64'(i), 64'(DEPTH));

    i = 0;
    n = 0;
    while (i < BEATS && n < BEATS * 8) begin
      sft_in_valid = (sfti_pat == 0) ? 1'b1 : (sfti_pat == 1) ? 1'(n % 2 == 0) : 1'($urandom_range(0, 1));
      acc = sft_in_valid && sft_in_ready;
      @(posedge clk);
      #2;
      n++;
      if (acc) i++;
    end
    sft_in_valid = 1'b0;
    chk("shift_in_accepted", i == BEATS, 64'(i), 64'(BEATS));

    if (glitch) begin
      while (cyc - start_cyc < DEPTH + BEATS + 6) begin @(posedge clk); #2; end
      start = 1'b1;
      mode = 2'($urandom);
      iter_num = 16'($urandom_range(5, 9));
      @(posedge clk);
      #2;
      start = 1'b0;
    end

    if (abort_at != 0) begin
      while (cyc - start_cyc < abort_at) begin @(posedge clk); #2; end
      #1 reset = 1'b1;
      #1 check_reset();
      wr_q.delete();
      sh_q.delete();
      sw_q.delete();
      dc_q.delete();
      @(posedge clk);
      #2;
      reset = 1'b0;
      @(posedge clk);
      #2;
    end else begin
      n = 0;
      while (!done_seen && n < WAIT_LIMIT) begin @(posedge clk); #2; n++; end
      chk("done_seen", done_seen, 64'(done_seen), 64'(1));
      @(posedge clk);
      #2;
      chk("done_one_cycle", done == 1'b0, 64'(done), 64'(0));
      chk("idle_busy", busy == 1'b0, 64'(busy), 64'(0));
      chk("left_writes", wr_q.size() == 0, 64'(wr_q.size()), 64'(0));
      chk("left_shifts", sh_q.size() == 0, 64'(sh_q.size()), 64'(0));
      chk("left_swaps", sw_q.size() == 0, 64'(sw_q.size()), 64'(0));
      chk("left_distance", dc_q.size() == 0, 64'(dc_q.size()), 64'(0));
      wr_q.delete();
      sh_q.delete();
      sw_q.delete();
      dc_q.delete();
    end
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : stimulus
    seq_or  = '{'{KN, ZERO}, '{KM, MNS}, '{KP, PLS}, '{KN, MNS}, '{LN, PLS}, '{LP, MNS}, '{KN, PLS}};
    seq_two = '{'{KN, ZERO}, '{KM, MNS}, '{LM, PLS}, '{LN, MNS}, '{KN, PLS}};
    repeat (3) @(posedge clk);
    #2;
    check_reset();
    reset = 1'b0;
    @(posedge clk);
    #2;
    run(2'd2, 1, 1'b0, 0, 1'b0, 0);
    run(2'd1, 3, 1'b0, 0, 1'b0, 0);
    run(2'd0, 0, 1'b0, 0, 1'b0, 0);
    run(2'd3, 2, 1'b0, 1, 1'b0, 0);
    run(2'd0, 4, 1'b0, 0, 1'b0, DEPTH + BEATS + ITER_CYC + 20);
    chk("restart_iter_cnt", iter_cnt == 16'd0, 64'(iter_cnt), 64'(0));
    run(2'd1, 2, 1'b0, 0, 1'b1, 0);
    for (int r = 0; r < 4; r++)
      run(2'($urandom), int'($urandom_range(0, 3)), 1'b1, 2, 1'b0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/replica_sequencer.md
# replica_sequencer

Synthesizable run controller for the replica array: it replaces the fixed simulation sequencing with a parametrised engine. It loads the distance RAM, shifts replicas in and out of the chain under handshake, and loops the distance/swap phases for a programmable iteration count with alternating exchange parity. It sits between the host interface and the replica chain and drives the registered command buses (`c_exchange`, `c_distance`, `rbank`) that all replicas share.

## Interface
Parameters:
- `REPLICA_NUM`, 4: replicas in chain (even, ≥2)
- `CITY_NUM`, 32: cities; distance depth `DIST_DEPTH = CITY_NUM*(CITY_NUM+1)/2`
- `CITY_DIV`, 4: beats per replica on the shift bus
- `DIST_CYC`, 20: cycles per DIST phase (≥8)
- `SWAP_CYC`, 10: cycles per SWAP phase (≥1)
- `ITER_W`, 16: iteration counter width

Ports:
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  run request; sampled only in IDLE
- `mode`  in  2  0=OR0, 1=OR1, 2=TWO, 3=reserved (treated as TWO); latched at start
- `iter_num`  in  ITER_W  DIST+SWAP iterations; latched at start
- `dist_in_valid` / `dist_in_ready`  in/out  1  distance load handshake
- `dist_in_data`  in  distance_data_t  distance entry
- `dist_we`, `dist_waddr`, `dist_wdata`  out  1 / city_num_log*2 / distance_data_t  distance RAM write port
- `sft_in_valid` / `sft_in_ready`  in/out  1  shift-in beat handshake
- `shift_valid`  out  1  beat present on chain head this cycle
- `shift_out`  out  1  high during SFTO beats
- `c_exchange`  out  2×exchange_command_t  [0] even replicas, [1] odd replicas
- `c_distance`  out  distance_command_t
- `opt_cmd`  out  opt command  latched mode, THR outside DIST/SWAP
- `rbank`  out  1  bank select
- `busy`  out  1  state ≠ IDLE
- `done`  out  1  one-cycle pulse at end of run
- `iter_cnt`  out  ITER_W  completed iterations

## Operation
- States: IDLE → LOAD → SFTI → (DIST → SWAP)×iter_num → SFTO → DONE → IDLE.
- IDLE: all outputs inactive; `start`=1 latches `mode`, `iter_num`, clears `iter_cnt`, goes LOAD. `start` outside IDLE ignored.
- LOAD: `dist_in_ready`=1; each accepted beat writes address 0,1,… with `dist_in_data`; after address DIST_DEPTH-1 accepted → SFTI. Stalls on `dist_in_valid`=0 hold the address.
- SFTI: `sft_in_ready`=1; each accepted beat asserts `shift_valid`; beat index b counts 0..REPLICA_NUM*CITY_DIV-1; when b%CITY_DIV==0, `c_exchange`={PREV,PREV}, else NOP. After last beat → DIST if iter_num>0, else SFTO.
- DIST: step counter s=0..DIST_CYC-1. OR0/OR1: s0 {KN,ZERO}, s1 {KM,MNS}, s2 {KP,PLS}, s3 {KN,MNS}, s4 {LN,PLS}, s5 {LP,MNS}, s6 {KN,PLS}. TWO: s0 {KN,ZERO}, s1 {KM,MNS}, s2 {LM,PLS}, s3 {LN,MNS}, s4 {KN,PLS}. Remaining steps {KN,DNOP}. → SWAP.
- SWAP: at s0, `c_exchange`={FOLW,PREV} when iter_cnt even (pairs 0-1,2-3,…), {PREV,FOLW} when odd; NOP otherwise. At s=SWAP_CYC-1: iter_cnt+1; if new iter_cnt==iter_num → SFTO else DIST.
- SFTO: free-running, no stalls; `shift_valid`=`shift_out`=1 for REPLICA_NUM*CITY_DIV cycles; exchange {PREV,PREV} on every b%CITY_DIV==0. → DONE.
- DONE: `done`=1 for one cycle → IDLE.
- `rbank` toggles on every cycle where `c_exchange`≠{NOP,NOP} is issued.
- Counters wrap-free: iter_cnt saturates at iter_num; iter_num=2^ITER_W-1 legal.

## Timing
- `c_exchange`, `c_distance`, `opt_cmd`, `shift_valid`, `dist_we/addr/data` are registered: appear 1 cycle after the state/beat that produces them. `rbank` updates same edge as the exchange it accompanies.
- `dist_in_ready`, `sft_in_ready` combinational from state only (no dependency on valid).
- Reset (async, any state): IDLE; `dist_we`=0, `shift_valid`=0, `shift_out`=0, `c_exchange`={NOP,NOP}, `c_distance`={KN,DNOP}, `opt_cmd`=THR, `rbank`=0, `busy`=0, `done`=0, `iter_cnt`=0, readies 0. Partial LOAD/SFTI data discarded.
- Run length with no stalls: DIST_DEPTH + 2·R·D + iter_num·(DIST_CYC+SWAP_CYC) + 1 cycles from start to `done` (R=REPLICA_NUM, D=CITY_DIV).

## Test plan
- Defaults, mode=TWO, iter_num=1, valids tied high → 528 writes addr 0..527, 16 shift-in beats with PREV at b=0,4,8,12, DIST steps {KN,ZERO},{KM,MNS},{LM,PLS},{LN,MNS},{KN,PLS}, one SWAP {FOLW,PREV}, 16 SFTO beats, `done` at cycle 528+32+30+1, rbank toggled 9 times.
- mode=OR1, iter_num=3 → 7-step DIST sequence each iteration; SWAP exchanges {FOLW,PREV},{PREV,FOLW},{FOLW,PREV}; iter_cnt ends 3.
- iter_num=0 → SFTI goes straight to SFTO; no c_distance other than {KN,DNOP}; opt_cmd stays THR.
- `sft_in_valid` toggling 1,0,1,0 → shift_valid only on accepted beats; b does not advance on stalls; 16 beats still delivered.
- Reset asserted at SWAP s0 of iteration 2 → all outputs at reset values asynchronously; next `start` restarts from LOAD addr 0, iter_cnt 0.
- `start` pulsed during DIST → ignored; latched mode/iter_num unchanged, run completes normally.
